// File: rtl/gelato_pkg.sv
// Shared types for the gelato warp scheduler slice.
// Holds the instruction word layout, default warp count and warp id type.
// No logic; imported by every scheduler file.
package gelato_pkg;

  localparam int WARP_NUM_DEF = 4;
  localparam int WARP_ID_W    = $clog2(WARP_NUM_DEF);

  typedef logic [WARP_ID_W-1:0] warp_id_t;

  typedef struct packed {
    logic [7:0]  opcode;
    logic [23:0] operand;
  } inst_t;

endpackage

// File: rtl/gelato_rr_arbiter.sv
// Round-robin picker: first set request scanning upward from ptr, with wrap.
// Purely combinational, zero latency.
// No backpressure of its own; the caller qualifies the grant.
module gelato_rr_arbiter #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] gnt_idx_o
);

  logic [W-1:0] cand;
  logic         found;

  // Walk the N candidates starting at ptr; N is a power of two so the index wraps for free.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr_i + W'(i);
      if (!found && req_i[cand]) begin
        found      = 1'b1;
        gnt_o[cand] = 1'b1;
        gnt_idx_o  = cand;
      end
    end
  end

endmodule

// File: rtl/gelato_warp_scheduler.sv
// Per-SM warp scheduler: round-robin pick of an eligible warp, barrier parking, one issue slot.
// Latency: buffer head to issue_valid is 1 cycle; back-to-back issue when dispatch keeps ready high.
// Backpressure: issue_ready low with a full slot blocks new grants; rdy low freezes everything.
module gelato_warp_scheduler
  import gelato_pkg::*;
#(
  parameter int WARP_NUM = WARP_NUM_DEF,
  parameter int WARP_W   = $clog2(WARP_NUM),
  parameter int CNT_W    = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       rdy,
  input  logic [WARP_NUM-1:0]        buf_valid,
  input  inst_t [WARP_NUM-1:0]       buf_inst,
  input  logic [WARP_NUM-1:0]        buf_is_bar,
  output logic [WARP_NUM-1:0]        buf_caught,
  input  logic [WARP_NUM-1:0]        warp_active,
  input  logic [WARP_NUM-1:0]        warp_stall,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output logic [WARP_W-1:0]          issue_warp,
  output inst_t                      issue_inst,
  output logic                       bar_release,
  output logic [CNT_W-1:0]           issued_cnt
);

  logic                issue_valid_q, issue_valid_d;
  logic [WARP_W-1:0]   issue_warp_q,  issue_warp_d;
  inst_t               issue_inst_q,  issue_inst_d;
  logic                bar_release_q, bar_release_d;
  logic [CNT_W-1:0]    issued_cnt_q,  issued_cnt_d;
  logic [WARP_NUM-1:0] bar_wait_q,    bar_wait_d;
  logic [WARP_W-1:0]   rr_ptr_q,      rr_ptr_d;

  logic [WARP_NUM-1:0] elig;
  logic [WARP_NUM-1:0] arb_gnt;
  logic [WARP_W-1:0]   arb_idx;
  logic [WARP_NUM-1:0] bar_active;
  logic                slot_free;
  logic                xfer;
  logic                grant_en;
  logic                grant_bar;
  logic                release_cond;

  assign elig       = warp_active & buf_valid & ~warp_stall & ~bar_wait_q;
  assign slot_free  = ~issue_valid_q | issue_ready;
  assign xfer       = issue_valid_q & issue_ready;
  // Reset is folded in so the pop pulse can never leak out while the slot is being cleared.
  assign grant_en   = rst_n & rdy & slot_free & (|elig);
  assign grant_bar  = buf_is_bar[arb_idx];
  assign buf_caught = grant_en ? arb_gnt : '0;

  // Exited warps drop out of the barrier; release once every remaining active warp is parked.
  assign bar_active   = bar_wait_q & warp_active;
  assign release_cond = (|warp_active) && (bar_active == warp_active);

  gelato_rr_arbiter #(
    .N (WARP_NUM),
    .W (WARP_W)
  ) u_arb (
    .req_i     (elig),
    .ptr_i     (rr_ptr_q),
    .gnt_o     (arb_gnt),
    .gnt_idx_o (arb_idx)
  );

  // Next-state: slot load/drain, pointer advance, barrier bookkeeping and counter; all held when rdy is low.
  always_comb begin
    issue_valid_d = issue_valid_q;
    issue_warp_d  = issue_warp_q;
    issue_inst_d  = issue_inst_q;
    bar_release_d = bar_release_q;
    issued_cnt_d  = issued_cnt_q;
    bar_wait_d    = bar_wait_q;
    rr_ptr_d      = rr_ptr_q;
    if (rdy) begin
      if (xfer) begin
        issued_cnt_d = issued_cnt_q + CNT_W'(1);
      end
      if (grant_en && !grant_bar) begin
        issue_valid_d = 1'b1;
        issue_warp_d  = arb_idx;
        issue_inst_d  = buf_inst[arb_idx];
      end else if (slot_free) begin
        issue_valid_d = 1'b0;
      end
      if (grant_en) begin
        rr_ptr_d = arb_idx + WARP_W'(1);
      end
      bar_release_d = release_cond;
      if (release_cond) begin
        bar_wait_d = '0;
      end else begin
        bar_wait_d = bar_active | ((grant_en && grant_bar) ? arb_gnt : '0);
      end
    end
  end

  // State registers with asynchronous clear of slot, barrier state, pointer and counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_valid_q <= 1'b0;
      issue_warp_q  <= '0;
      issue_inst_q  <= '0;
      bar_release_q <= 1'b0;
      issued_cnt_q  <= '0;
      bar_wait_q    <= '0;
      rr_ptr_q      <= '0;
    end else begin
      issue_valid_q <= issue_valid_d;
      issue_warp_q  <= issue_warp_d;
      issue_inst_q  <= issue_inst_d;
      bar_release_q <= bar_release_d;
      issued_cnt_q  <= issued_cnt_d;
      bar_wait_q    <= bar_wait_d;
      rr_ptr_q      <= rr_ptr_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign issue_warp  = issue_warp_q;
  assign issue_inst  = issue_inst_q;
  assign bar_release = bar_release_q;
  assign issued_cnt  = issued_cnt_q;

endmodule

// File: tb/tb_gelato_warp_scheduler.sv
// Directed bench for gelato_warp_scheduler with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Covers round-robin order, backpressure, stalls, barriers, warp exit and mid-stream reset.
module tb_gelato_warp_scheduler;
  import gelato_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic [3:0]  buf_valid;
  inst_t [3:0] buf_inst;
  logic [3:0]  buf_is_bar;
  logic [3:0]  buf_caught;
  logic [3:0]  warp_active;
  logic [3:0]  warp_stall;
  logic        issue_valid;
  logic        issue_ready;
  logic [1:0]  issue_warp;
  inst_t       issue_inst;
  logic        bar_release;
  logic [31:0] issued_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  gelato_warp_scheduler dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rdy         (rdy),
    .buf_valid   (buf_valid),
    .buf_inst    (buf_inst),
    .buf_is_bar  (buf_is_bar),
    .buf_caught  (buf_caught),
    .warp_active (warp_active),
    .warp_stall  (warp_stall),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .issue_warp  (issue_warp),
    .issue_inst  (issue_inst),
    .bar_release (bar_release),
    .issued_cnt  (issued_cnt)
  );

  always #5 clk = ~clk;

  function automatic inst_t exp_inst(input int w);
    inst_t r;
    r.opcode  = 8'h10 + 8'(w);
    r.operand = 24'(w * 'h111) + 24'h00_0a00;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ordinary grant to warp w: pop pulse now, slot loaded with w one edge later.
  task automatic grant_step(input string tag, input int w);
    #1;
    chk({tag, "_caught"}, 32'(buf_caught), 32'(4'b0001 << w));
    tick();
    chk({tag, "_valid"}, 32'(issue_valid), 32'd1);
    chk({tag, "_warp"}, 32'(issue_warp), 32'(w));
    chk({tag, "_inst"}, 32'(issue_inst), 32'(exp_inst(w)));
  endtask

  // Barrier grant to warp w: pop pulse now, no issue, warp parked one edge later.
  task automatic bar_step(input string tag, input int w, input logic [3:0] exp_wait);
    #1;
    chk({tag, "_caught"}, 32'(buf_caught), 32'(4'b0001 << w));
    tick();
    chk({tag, "_noissue"}, 32'(issue_valid), 32'd0);
    chk({tag, "_wait"}, 32'(dut.bar_wait_q), 32'(exp_wait));
  endtask

  initial begin
    rst_n       = 1'b0;
    rdy         = 1'b1;
    issue_ready = 1'b1;
    buf_valid   = 4'hF;
    buf_is_bar  = 4'h0;
    warp_active = 4'hF;
    warp_stall  = 4'h0;
    for (int i = 0; i < 4; i++) buf_inst[i] = exp_inst(i);

    // Reset state, and no pop pulse while reset is held even though warps look eligible.
    tick();
    chk("rst_valid",  32'(issue_valid), 32'd0);
    chk("rst_warp",   32'(issue_warp),  32'd0);
    chk("rst_inst",   32'(issue_inst),  32'd0);
    chk("rst_rel",    32'(bar_release), 32'd0);
    chk("rst_cnt",    issued_cnt,       32'd0);
    chk("rst_caught", 32'(buf_caught),  32'd0);
    rst_n = 1'b1;

    // 1: all valid, ready held: 0,1,2,3,0,1,2,3 then drain -> 8 transfers.
    for (int k = 0; k < 8; k++) grant_step("t1", k % 4);
    buf_valid = 4'h0;
    tick();
    chk("t1_cnt",   issued_cnt,       32'd8);
    chk("t1_drain", 32'(issue_valid), 32'd0);

    // 2: slot full with ready low for 3 cycles; then transfer + new grant together.
    buf_valid   = 4'hF;
    issue_ready = 1'b0;
    grant_step("t2_fill", 0);
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t2_hold_caught", 32'(buf_caught), 32'd0);
      tick();
      chk("t2_hold_inst",  32'(issue_inst), 32'(exp_inst(0)));
      chk("t2_hold_valid", 32'(issue_valid), 32'd1);
      chk("t2_hold_cnt",   issued_cnt, 32'd8);
    end
    issue_ready = 1'b1;
    grant_step("t2_b2b", 1);
    chk("t2_cnt9", issued_cnt, 32'd9);
    buf_valid = 4'h0;
    tick();
    chk("t2_cnt10", issued_cnt, 32'd10);

    // 3: warp 1 stalled, pointer at 2 -> 2,3,0,2; stall drops -> 3,0,1.
    buf_valid  = 4'hF;
    warp_stall = 4'b0010;
    grant_step("t3_s", 2);
    grant_step("t3_s", 3);
    grant_step("t3_s", 0);
    grant_step("t3_s", 2);
    warp_stall = 4'b0000;
    grant_step("t3_u", 3);
    grant_step("t3_u", 0);
    grant_step("t3_u", 1);
    buf_valid = 4'h0;
    tick();
    chk("t3_cnt", issued_cnt, 32'd17);

    // 4: barrier heads on warps 0..2 (the only active ones), pointer at 3 after warp 2 is taken.
    warp_active = 4'b0111;
    buf_valid   = 4'b0111;
    buf_is_bar  = 4'b0111;
    bar_step("t4_b2", 2, 4'b0100);
    bar_step("t4_b0", 0, 4'b0101);
    bar_step("t4_b1", 1, 4'b0111);
    #1;
    chk("t4_all_parked_caught", 32'(buf_caught), 32'd0);
    chk("t4_rel_not_yet", 32'(bar_release), 32'd0);
    tick();
    chk("t4_rel_pulse", 32'(bar_release), 32'd1);
    chk("t4_wait_clr",  32'(dut.bar_wait_q), 32'd0);
    #1;
    chk("t4_elig_again", 32'(buf_caught), 32'b0100);
    buf_is_bar = 4'b0000;
    tick();
    chk("t4_rel_end", 32'(bar_release), 32'd0);
    chk("t4_issue",   32'(issue_valid), 32'd1);
    chk("t4_warp",    32'(issue_warp),  32'd2);
    buf_valid = 4'h0;
    tick();
    chk("t4_cnt", issued_cnt, 32'd18);

    // 5: warps 0,1 park, warp 2 active but absent; its exit releases the barrier.
    warp_active = 4'b0111;
    buf_valid   = 4'b0011;
    buf_is_bar  = 4'b0011;
    bar_step("t5_b0", 0, 4'b0001);
    bar_step("t5_b1", 1, 4'b0011);
    #1;
    chk("t5_idle_caught", 32'(buf_caught), 32'd0);
    tick();
    chk("t5_no_rel",  32'(bar_release), 32'd0);
    chk("t5_waiting", 32'(dut.bar_wait_q), 32'b0011);
    warp_active = 4'b0011;
    #1;
    chk("t5_exit_caught", 32'(buf_caught), 32'd0);
    tick();
    chk("t5_rel",      32'(bar_release), 32'd1);
    chk("t5_wait_clr", 32'(dut.bar_wait_q), 32'd0);
    buf_valid   = 4'h0;
    buf_is_bar  = 4'h0;
    warp_active = 4'hF;
    tick();
    chk("t5_rel_end", 32'(bar_release), 32'd0);

    // 6: reset with the slot full, then first grant goes to lowest valid warp from pointer 0.
    buf_valid   = 4'hF;
    issue_ready = 1'b0;
    grant_step("t6_fill", 2);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid",  32'(issue_valid), 32'd0);
    chk("t6_rst_cnt",    issued_cnt,       32'd0);
    chk("t6_rst_caught", 32'(buf_caught),  32'd0);
    chk("t6_rst_warp",   32'(issue_warp),  32'd0);
    tick();
    rst_n       = 1'b1;
    buf_valid   = 4'b1100;
    issue_ready = 1'b1;
    grant_step("t6_post", 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
